// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: 4-entry byte FIFO feeding an LSB-first serializer
// on a runtime baud divisor. Optional even parity bit under `UART_TX_PARITY_EN`.
module uart_tx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trmt,
    input  logic [7:0]  tx_data,
    input  logic [12:0] baud,
    output logic        TX,
    output logic        tx_done,
    output logic        busy,
    output logic        full,
    output logic        empty
);

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;
    state_t r_state, w_state_nxt;

    logic [7:0]            r_mem [4];
    logic [1:0]            r_wr_ptr, r_rd_ptr;
    logic [2:0]            r_count;
    logic [FRAME_BITS-1:0] r_shift, w_frame;
    logic [12:0]           r_baud_cnt, r_baud_lat;
    logic [3:0]            r_bit_cnt;
    logic                  r_tx_done;
    logic                  w_push, w_pop, w_load, w_shift, w_done, w_bit_end;
    logic [7:0]            w_head;

    assign w_head    = r_mem[r_rd_ptr];
    assign w_push    = trmt && !full;
    assign w_bit_end = (r_baud_cnt == 13'd0);

`ifdef UART_TX_PARITY_EN
    assign w_frame = {1'b1, ^w_head, w_head, 1'b0};
`else
    assign w_frame = {1'b1, w_head, 1'b0};
`endif

    assign TX      = r_shift[0];
    assign tx_done = r_tx_done;
    assign busy    = (r_state == S_SHIFT);
    assign full    = (r_count == 3'd4);
    assign empty   = (r_count == 3'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!empty) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_done = 1'b1;
                        // Reload straight from the FIFO so the next start bit follows the stop bit with no gap.
                        if (!empty) begin
                            w_pop  = 1'b1;
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '1;
            r_baud_cnt <= '0;
            r_baud_lat <= '0;
            r_bit_cnt  <= '0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= w_done;
            if (w_load) begin
                r_shift    <= w_frame;
                r_baud_lat <= baud;
                r_baud_cnt <= baud - 13'd1;
                r_bit_cnt  <= '0;
            end else if (w_shift) begin
                r_shift    <= {1'b1, r_shift[FRAME_BITS-1:1]};
                r_baud_cnt <= r_baud_lat - 13'd1;
                r_bit_cnt  <= r_bit_cnt + 4'd1;
            end else if (w_done) begin
                r_shift <= '1;
            end else if (r_state == S_SHIFT) begin
                r_baud_cnt <= r_baud_cnt - 13'd1;
            end
        end
    end

    // A write while full is dropped even if a pop frees a slot in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= tx_data;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: random bytes and divisors compared cycle by cycle against a
// frame-level model of the serial waveform.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trmt;
    logic [7:0]  tx_data;
    logic [12:0] baud;
    logic        TX, tx_done, busy, full, empty;

    int checks = 0;
    int errors = 0;

`ifdef UART_TX_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif

    logic [7:0] exp_q[$];

    uart_tx dut (
        .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data), .baud(baud),
        .TX(TX), .tx_done(tx_done), .busy(busy), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Bit k of the frame carrying byte d: start, d[0..7], [parity], stop.
    function automatic logic model_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic push(input logic [7:0] d);
        @(posedge clk);
        #1 trmt = 1'b1; tx_data = d;
        @(posedge clk);
        #1 trmt = 1'b0;
    endtask

    // Called at the negedge of cycle c+1; checks every cycle of the queued frames from c+2 on.
    task automatic check_stream(input int bd, input string tag);
        int   per;
        int   total;
        logic exp_tx, exp_done, exp_busy;
        per   = F * bd;
        total = per * exp_q.size();
        for (int t = 0; t <= total + 1; t++) begin
            @(negedge clk);
            exp_tx   = (t < total) ? model_bit(exp_q[t / per], (t % per) / bd) : 1'b1;
            exp_done = (t > 0) && (t <= total) && (t % per == 0);
            exp_busy = (t < total);
            checks++;
            if (TX !== exp_tx) begin
                errors++;
                $display("FAIL %s_tx t=%0d got %b want %b", tag, t, TX, exp_tx);
            end
            checks++;
            if (tx_done !== exp_done) begin
                errors++;
                $display("FAIL %s_done t=%0d got %b want %b", tag, t, tx_done, exp_done);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL %s_busy t=%0d got %b want %b", tag, t, busy, exp_busy);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL %s_empty_after got %b want 1", tag, empty);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; trmt = 1'b0; tx_data = 8'h00; baud = 13'd16;
        #3 rst_n = 1'b0;
        #2;
        checks++;
        if ({TX, busy, tx_done, full, empty} !== 5'b10001) begin
            errors++;
            $display("FAIL reset_state got %b want 10001", {TX, busy, tx_done, full, empty});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({TX, busy, tx_done, full, empty} !== 5'b10001) begin
                errors++;
                $display("FAIL idle_state cyc=%0d got %b want 10001", i, {TX, busy, tx_done, full, empty});
            end
        end
    endtask

    task automatic test_single(input logic [7:0] d, input int bd);
        baud = 13'(bd);
        push(d);
        @(negedge clk);
        checks++;
        if ({empty, busy, TX} !== 3'b001) begin
            errors++;
            $display("FAIL single_c1 got %b want 001", {empty, busy, TX});
        end
        exp_q.push_back(d);
        check_stream(bd, "single");
    endtask

    task automatic test_back_to_back();
        logic [7:0] d[6];
        for (int i = 0; i < 6; i++) d[i] = 8'($urandom);
        baud = 13'd16;
        push(d[0]);
        @(negedge clk);
        // d[0] is on the line, d[1..4] fill the FIFO, d[5] hits a full FIFO.
        for (int i = 0; i < 5; i++) exp_q.push_back(d[i]);
        fork
            check_stream(16, "b2b");
            begin
                repeat (3) @(posedge clk);
                for (int i = 1; i < 5; i++) begin
                    #1 trmt = 1'b1; tx_data = d[i];
                    @(posedge clk);
                end
                #1 trmt = 1'b1; tx_data = d[5];
                @(negedge clk);
                checks++;
                if (full !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_full got %b want 1", full);
                end
                @(posedge clk);
                #1 trmt = 1'b0;
            end
        join
    endtask

    task automatic test_baud_change();
        baud = 13'd16;
        push(8'h55);
        @(negedge clk);
        exp_q.push_back(8'h55);
        fork
            check_stream(16, "baud16");
            begin
                repeat (40) @(posedge clk);
                #1 baud = 13'd32;
            end
        join
        push(8'hAA);
        @(negedge clk);
        exp_q.push_back(8'hAA);
        check_stream(32, "baud32");
    endtask

    task automatic test_reset_midframe(input logic [7:0] d);
        baud = 13'd16;
        push(d);
        push(8'h3C);
        // Frame started at c+2; data bit 3 occupies cycles c+66..c+81.
        repeat (70) @(posedge clk);
        #2;
        checks++;
        if ({busy, TX} !== {1'b1, d[3]}) begin
            errors++;
            $display("FAIL rst_pre got %b want %b", {busy, TX}, {1'b1, d[3]});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({TX, busy, tx_done, full, empty} !== 5'b10001) begin
            errors++;
            $display("FAIL rst_mid got %b want 10001", {TX, busy, tx_done, full, empty});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            checks++;
            if ({TX, busy, tx_done, empty} !== 4'b1001) begin
                errors++;
                $display("FAIL rst_after cyc=%0d got %b want 1001", i, {TX, busy, tx_done, empty});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single(8'hA5, 16);
        test_single(8'h07, 16);
        test_single(8'($urandom), 2);
        for (int i = 0; i < 5; i++) test_single(8'($urandom), int'($urandom_range(2, 20)));
        test_back_to_back();
        test_baud_change();
        test_reset_midframe(8'hFF);
        test_reset_midframe(8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
